// File: rtl/axis_frame_len_stats.sv
// rtl/axis_frame_len_stats.sv - per-period frame length statistics with snapshot latch
// Live accumulators fold in each reported frame; a snapshot copies them to stat_* and restarts the period.
module axis_frame_len_stats #(
   parameter int LEN_WIDTH   = 16,
   parameter int COUNT_WIDTH = 32,
   parameter int MIN_LEN     = 64,
   parameter int MAX_LEN     = 1518
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LEN_WIDTH-1:0]   frame_len,
   input  logic                   frame_len_valid,
   input  logic                   snapshot,
   output logic [COUNT_WIDTH-1:0] stat_frames,
   output logic [COUNT_WIDTH-1:0] stat_bytes,
   output logic [LEN_WIDTH-1:0]   stat_min_len,
   output logic [LEN_WIDTH-1:0]   stat_max_len,
   output logic [COUNT_WIDTH-1:0] stat_runt,
   output logic [COUNT_WIDTH-1:0] stat_oversize,
   output logic                   stat_valid
);

   // One spare bit above the wider operand so a byte-sum overflow is visible before clamping.
   localparam int SUM_WIDTH = ((COUNT_WIDTH > LEN_WIDTH) ? COUNT_WIDTH : LEN_WIDTH) + 1;
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [LEN_WIDTH-1:0]   LEN_MAX    = '1;
   localparam logic [LEN_WIDTH-1:0]   RUNT_BELOW = LEN_WIDTH'(MIN_LEN);
   localparam logic [LEN_WIDTH-1:0]   OVER_ABOVE = LEN_WIDTH'(MAX_LEN);

   logic [COUNT_WIDTH-1:0] live_frames, live_bytes, live_runt, live_over;
   logic [LEN_WIDTH-1:0]   live_min, live_max;

   logic [COUNT_WIDTH-1:0] acc_frames, acc_bytes, acc_runt, acc_over;
   logic [LEN_WIDTH-1:0]   acc_min, acc_max;
   logic [SUM_WIDTH-1:0]   byte_sum;

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v,
                                                      input logic en);
      return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
   endfunction

   // Accumulator values including the current cycle's frame, so a coincident snapshot captures it.
   always_comb begin
      acc_frames = live_frames;
      acc_bytes  = live_bytes;
      acc_min    = live_min;
      acc_max    = live_max;
      acc_runt   = live_runt;
      acc_over   = live_over;
      byte_sum   = SUM_WIDTH'(live_bytes) + SUM_WIDTH'(frame_len);
      if (frame_len_valid) begin
         acc_frames = sat_inc(live_frames, 1'b1);
         acc_bytes  = (byte_sum > SUM_WIDTH'(CNT_MAX)) ? CNT_MAX : byte_sum[COUNT_WIDTH-1:0];
         if (frame_len < live_min) acc_min = frame_len;
         if (frame_len > live_max) acc_max = frame_len;
         acc_runt   = sat_inc(live_runt, frame_len < RUNT_BELOW);
         acc_over   = sat_inc(live_over, frame_len > OVER_ABOVE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         live_frames   <= '0;
         live_bytes    <= '0;
         live_min      <= LEN_MAX;
         live_max      <= '0;
         live_runt     <= '0;
         live_over     <= '0;
         stat_frames   <= '0;
         stat_bytes    <= '0;
         stat_min_len  <= LEN_MAX;
         stat_max_len  <= '0;
         stat_runt     <= '0;
         stat_oversize <= '0;
         stat_valid    <= 1'b0;
      end else begin
         stat_valid <= snapshot;
         if (snapshot) begin
            stat_frames   <= acc_frames;
            stat_bytes    <= acc_bytes;
            stat_min_len  <= acc_min;
            stat_max_len  <= acc_max;
            stat_runt     <= acc_runt;
            stat_oversize <= acc_over;
            live_frames   <= '0;
            live_bytes    <= '0;
            live_min      <= LEN_MAX;
            live_max      <= '0;
            live_runt     <= '0;
            live_over     <= '0;
         end else begin
            live_frames <= acc_frames;
            live_bytes  <= acc_bytes;
            live_min    <= acc_min;
            live_max    <= acc_max;
            live_runt   <= acc_runt;
            live_over   <= acc_over;
         end
      end
   end

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// tb/tb_axis_frame_len_stats.sv - scoreboard bench for axis_frame_len_stats
// Default instance checked on every snapshot; an 8-bit-counter instance checks saturation.
module tb_axis_frame_len_stats;

   typedef struct packed {
      logic [31:0] frames;
      logic [31:0] bytes;
      logic [15:0] mn;
      logic [15:0] mx;
      logic [31:0] runt;
      logic [31:0] over;
   } stats_t;

   typedef struct {
      int          n;
      logic [15:0] lens [4];
      stats_t      exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] frame_len = '0;
   logic        frame_len_valid = 1'b0;
   logic        snapshot = 1'b0;

   logic [31:0] stat_frames, stat_bytes, stat_runt, stat_oversize;
   logic [15:0] stat_min_len, stat_max_len;
   logic        stat_valid;

   logic [7:0]  s8_frames, s8_bytes, s8_runt, s8_oversize;
   logic [15:0] s8_min_len, s8_max_len;
   logic        s8_valid;

   int     tests = 0;
   int     failed = 0;
   stats_t exp_q[$];
   stats_t q8[$];
   stats_t cur, cur8, prev, empty_s;
   vec_t   vecs[6];
   logic   mon_on = 1'b0;
   logic   rst_at_edge = 1'b1;

   always #5 clk = ~clk;

   axis_frame_len_stats dut (
      .clk(clk), .rst(rst), .frame_len(frame_len), .frame_len_valid(frame_len_valid),
      .snapshot(snapshot), .stat_frames(stat_frames), .stat_bytes(stat_bytes),
      .stat_min_len(stat_min_len), .stat_max_len(stat_max_len), .stat_runt(stat_runt),
      .stat_oversize(stat_oversize), .stat_valid(stat_valid)
   );

   axis_frame_len_stats #(.COUNT_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .frame_len(frame_len), .frame_len_valid(frame_len_valid),
      .snapshot(snapshot), .stat_frames(s8_frames), .stat_bytes(s8_bytes),
      .stat_min_len(s8_min_len), .stat_max_len(s8_max_len), .stat_runt(s8_runt),
      .stat_oversize(s8_oversize), .stat_valid(s8_valid)
   );

   always_comb begin
      cur  = {stat_frames, stat_bytes, stat_min_len, stat_max_len, stat_runt, stat_oversize};
      cur8 = {24'd0, s8_frames, 24'd0, s8_bytes, s8_min_len, s8_max_len,
              24'd0, s8_runt, 24'd0, s8_oversize};
   end

   function automatic stats_t mk(input int f, input int b, input int mn, input int mx,
                                 input int r, input int o);
      stats_t s;
      s.frames = f; s.bytes = b; s.mn = mn[15:0]; s.mx = mx[15:0]; s.runt = r; s.over = o;
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         failed++;
         $display("FAIL %s: got %0d required %0d", tag, got, want);
      end
   endtask

   task automatic check_stats(input string tag, input stats_t g, input stats_t e);
      chk({tag, ".frames"}, g.frames, e.frames);
      chk({tag, ".bytes"},  g.bytes,  e.bytes);
      chk({tag, ".min"},    {16'd0, g.mn}, {16'd0, e.mn});
      chk({tag, ".max"},    {16'd0, g.mx}, {16'd0, e.mx});
      chk({tag, ".runt"},   g.runt,   e.runt);
      chk({tag, ".over"},   g.over,   e.over);
   endtask

   task automatic cycle(input logic v, input logic [15:0] len, input logic s);
      frame_len_valid = v;
      frame_len       = len;
      snapshot        = s;
      @(posedge clk);
      #1;
      frame_len_valid = 1'b0;
      snapshot        = 1'b0;
   endtask

   task automatic snap(input stats_t e);
      exp_q.push_back(e);
      cycle(1'b0, 16'd7, 1'b1);
   endtask

   task automatic set_vec(input int i, input int n, input int l0, input int l1, input int l2,
                          input int l3, input stats_t e);
      vecs[i].n = n;
      vecs[i].lens[0] = l0[15:0]; vecs[i].lens[1] = l1[15:0];
      vecs[i].lens[2] = l2[15:0]; vecs[i].lens[3] = l3[15:0];
      vecs[i].exp = e;
   endtask

   always @(posedge clk) rst_at_edge <= rst;

   // Scoreboard: each stat_valid pulse pops one expectation; quiet cycles must hold stat_* steady.
   always @(negedge clk) begin
      if (mon_on) begin
         if (stat_valid) begin
            if (exp_q.size() == 0) begin
               tests++; failed++;
               $display("FAIL unexpected_stat_valid: got 1 required 0");
            end else begin
               check_stats("snap", cur, exp_q.pop_front());
            end
         end else if (!rst_at_edge) begin
            tests++;
            if (cur !== prev) begin
               failed++;
               $display("FAIL stat_hold: got %h required %h", cur, prev);
            end
         end
         prev = cur;
         if (s8_valid && q8.size() > 0) check_stats("snap8", cur8, q8.pop_front());
      end
   end

   initial begin
      empty_s = mk(0, 0, 16'hFFFF, 0, 0, 0);
      set_vec(0, 4, 60, 64, 1518, 1519,  mk(4, 3161, 60, 1519, 1, 1));
      set_vec(1, 0, 0, 0, 0, 0,          empty_s);
      set_vec(2, 1, 0, 0, 0, 0,          mk(1, 0, 0, 0, 1, 0));
      set_vec(3, 4, 63, 1518, 64, 65535, mk(4, 67180, 63, 65535, 1, 1));
      set_vec(4, 2, 1000, 1000, 0, 0,    mk(2, 2000, 1000, 1000, 0, 0));
      set_vec(5, 3, 1519, 2000, 9000, 0, mk(3, 12519, 1519, 9000, 0, 3));

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_stats("reset", cur, empty_s);
      chk("reset.valid", {31'd0, stat_valid}, 32'd0);
      prev   = cur;
      mon_on = 1'b1;

      // Back-to-back frames, an ignored idle cycle with junk length, then snapshot.
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < vecs[i].n; k++) cycle(1'b1, vecs[i].lens[k], 1'b0);
         cycle(1'b0, 16'd5, 1'b0);
         snap(vecs[i].exp);
         cycle(1'b0, 16'd0, 1'b0);
      end

      // Frame coincident with snapshot is included; following period is empty.
      exp_q.push_back(mk(1, 100, 100, 100, 0, 0));
      cycle(1'b1, 16'd100, 1'b1);
      snap(empty_s);
      cycle(1'b0, 16'd0, 1'b0);

      // Snapshot on two consecutive cycles.
      cycle(1'b1, 16'd200, 1'b0);
      snap(mk(1, 200, 200, 200, 0, 0));
      snap(empty_s);
      repeat (2) cycle(1'b0, 16'd0, 1'b0);

      // Saturation of the 8-bit counters; the 32-bit instance counts on.
      for (int k = 0; k < 300; k++) cycle(1'b1, 16'd1, 1'b0);
      q8.push_back(mk(255, 255, 1, 1, 255, 0));
      snap(mk(300, 300, 1, 1, 300, 0));
      repeat (2) cycle(1'b0, 16'd0, 1'b0);

      // Reset mid-period wins over a coincident snapshot and frame.
      for (int k = 0; k < 5; k++) cycle(1'b1, 16'(100 + k), 1'b0);
      rst = 1'b1;
      cycle(1'b1, 16'd500, 1'b1);
      check_stats("midreset", cur, empty_s);
      chk("midreset.valid", {31'd0, stat_valid}, 32'd0);
      cycle(1'b0, 16'd0, 1'b0);
      rst = 1'b0;
      cycle(1'b1, 16'd70, 1'b0);
      cycle(1'b1, 16'd80, 1'b0);
      snap(mk(2, 150, 70, 80, 0, 0));
      repeat (3) cycle(1'b0, 16'd0, 1'b0);

      chk("pending_expect", exp_q.size(), 32'd0);
      chk("pending_expect8", q8.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/axis_frame_len_stats.md
AXIS_FRAME_LEN_STATS -- requirements
Module: axis_frame_len_stats

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16: width of incoming frame length.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32: width of the frame, byte, runt and oversize counters.
REQ-003 SHALL have parameter MIN_LEN, default 64: frames with length strictly below this are runts.
REQ-004 SHALL have parameter MAX_LEN, default 1518: frames with length strictly above this are oversize.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port frame_len  input  LEN_WIDTH  byte length of a completed frame from the upstream frame-length stage.
REQ-008 SHALL have port frame_len_valid  input  1  single-cycle qualifier for frame_len; no ready, never back-pressured.
REQ-009 SHALL have port snapshot  input  1  pulse: latch live statistics to outputs and clear live accumulators.
REQ-010 SHALL have port stat_frames  output  COUNT_WIDTH  frames in last snapshot period.
REQ-011 SHALL have port stat_bytes  output  COUNT_WIDTH  sum of frame_len in period.
REQ-012 SHALL have port stat_min_len  output  LEN_WIDTH  smallest frame_len in period.
REQ-013 SHALL have port stat_max_len  output  LEN_WIDTH  largest frame_len in period.
REQ-014 SHALL have port stat_runt  output  COUNT_WIDTH  runt count in period.
REQ-015 SHALL have port stat_oversize  output  COUNT_WIDTH  oversize count in period.
REQ-016 SHALL have port stat_valid  output  1  one-cycle pulse when stat_* are updated.

Function
REQ-017 SHALL keep live accumulators: frames, bytes, min, max, runt, oversize; idle values 0, 0, all-ones, 0, 0, 0.
REQ-018 SHALL, on each cycle with frame_len_valid=1, update the live accumulators as follows: frames+1; bytes+frame_len, with frame_len zero-extended to COUNT_WIDTH; min=min(min,frame_len); max=max(max,frame_len); runt+1 if frame_len<MIN_LEN; oversize+1 if frame_len>MAX_LEN.
REQ-019 SHALL saturate every counter at all-ones, with no wrap; the saturated value holds until cleared.
REQ-020 SHALL treat frame_len=0 as a valid frame: it counts, is a runt, and sets min to 0.
REQ-021 SHALL, on a cycle with snapshot=1, load stat_* on the next rising edge with the live values, including any frame_len_valid in that same cycle, and clear the live accumulators to idle values on that same edge.
REQ-022 SHALL assert stat_valid for exactly one cycle, the cycle after the snapshot input cycle; latency is 1 clock.
REQ-023 SHALL accept back-to-back snapshot pulses; each produces its own stat_valid pulse and a fresh period; an empty period reports 0, 0, all-ones, 0, 0, 0.
REQ-024 SHALL hold stat_* stable between snapshots, regardless of frame_len_valid activity.
REQ-025 SHALL accept frame_len_valid on every consecutive cycle with no lost frames.
REQ-026 SHALL ignore frame_len whenever frame_len_valid=0.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, set the live accumulators to their idle values, set stat_frames, stat_bytes, stat_runt, stat_oversize and stat_max_len to 0, set stat_min_len to all-ones, and set stat_valid to 0.
REQ-028 SHALL give rst priority over snapshot and frame_len_valid in the same cycle; in that case no stat_valid pulse follows and the frame is discarded.
REQ-029 SHALL resume normal accumulation on the first cycle after rst deasserts.

Verification
REQ-030 SHALL be verified with this scenario: frames of length 60, 64, 1518, 1519, then snapshot -> next cycle stat_valid=1, frames=4, bytes=3161, min=60, max=1519, runt=1, oversize=1.
REQ-031 SHALL be verified with this scenario: snapshot with no prior frames -> stat_valid=1, frames=0, bytes=0, min=0xFFFF, max=0, runt=0, oversize=0.
REQ-032 SHALL be verified with this scenario: frame_len_valid with length 100 in the same cycle as snapshot -> the snapshot includes it (frames=1, bytes=100); the next period starts empty.
REQ-033 SHALL be verified with this scenario: COUNT_WIDTH=8 and 300 frames of length 1 -> stat_frames=255 and stat_bytes=255 (saturated), with no wrap.
REQ-034 SHALL be verified with this scenario: rst asserted mid-period after 5 frames, then 2 frames, then snapshot -> frames=2, and no stat_valid pulse during reset.
REQ-035 SHALL be verified with this scenario: snapshot on two consecutive cycles with one frame of length 200 before the first -> first pulse frames=1, bytes=200; second pulse frames=0, min=0xFFFF.
